mul_div_unit_div: RTL and testbench
===================================

Name: mul_div_unit_div

Overview:
- Multi-cycle 32-bit radix-2 restoring divider in the execute stage. Serves DIV/DIVU.
- Produces the quotient and remainder that the HI/LO write path consumes.
- Produces the busy/ready handshake the hazard unit uses to stall F/D/E/M/W while a division is in flight.
- Supports abort of an in-flight division on pipeline flush (exception in M).

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous, active-low reset
- start  input  1  division request from E stage; held high until ready is seen
- signed_div  input  1  1 = DIV (signed), 0 = DIVU
- opdata1  input  DATA_W  dividend (rs)
- opdata2  input  DATA_W  divisor (rt)
- annul  input  1  abort current division (flushE / exception)
- result  output  2*DATA_W  {remainder → HI, quotient → LO}
- ready  output  1  result valid
- stall_div  output  1  equals start & ~ready; drives the stall_divE input of the hazard unit

Behaviour:
- Reset (async, resetn=0): state=IDLE, counter=0, result=0, ready=0, stall_div=0. Asserting reset mid-division discards all work.
- Register state: state, counter, partial remainder/quotient shift register (2*DATA_W+1 bits), latched sign info, result.
- States: IDLE, DIVBYZERO, ON, END.
- IDLE:
  - start=1 & annul=0 & opdata2==0 → DIVBYZERO.
  - start=1 & annul=0 & opdata2!=0 → ON.
  - On entry to ON: latch magnitudes |opdata1| and |opdata2| (two's-complement negate only when signed_div=1 and the MSB is 1), latch the quotient sign (op1 MSB XOR op2 MSB) & signed_div, latch the remainder sign (op1 MSB) & signed_div, and set counter=0.
  - Operands are not sampled again after the accepting edge.
- ON, one quotient bit per cycle:
  - Shift the partial remainder left one bit.
  - Trial-subtract the divisor. If non-negative, keep the difference and shift in 1; else shift in 0.
  - counter increments each cycle.
  - When counter==DATA_W-1, go to END next cycle and register the result.
  - Result fix-up: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - The magnitude of -2^31 is 0x80000000 treated as unsigned. -2^31 / -1 gives quotient 0x80000000 (wraps) and remainder 0.
- DIVBYZERO: go to END next cycle with result = {opdata1 latched, 32'hFFFFFFFF}.
- END:
  - ready=1 and result stable.
  - When start=0, go to IDLE next cycle; ready drops on that edge.
  - While start stays 1, remain in END and do not restart.
- Latency: start sampled at edge 0 → ready high after edge 33 (normal) or after edge 2 (divide by zero).
- annul=1 in any state → IDLE on the next edge, ready=0, result unchanged. annul takes priority over start and over the ON→END transition.
- Simultaneous start and annul in IDLE: the request is ignored.
- stall_div is purely combinational from start and ready, so it is asserted in the cycle start first rises.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- With it defined: in IDLE on an accepted start, if opdata2!=0 and |opdata1| < |opdata2| (unsigned magnitudes), go directly to END. Result = {opdata1, 0}, i.e. remainder = the original signed dividend and quotient 0. ready rises after edge 2.
- Without it: all non-zero divisors take the full 33-cycle path.
- Results are identical either way; only latency differs.

Test Plan:
- Unsigned: start=1, signed_div=0, op1=100, op2=7 → ready after 33 edges, result={32'd2, 32'd14}, stall_div=1 until then. Then drop start → ready=0 next cycle.
- Signed: op1=-7 (0xFFFFFFF9), op2=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also op1=0x80000000, op2=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: op1=0x12345678, op2=0 → ready after 2 edges, result={0x12345678, 0xFFFFFFFF}.
- Annul at counter=10 → IDLE next edge, ready never asserts. A new request 5/2 afterwards completes normally: {1, 2}.
- resetn pulsed low mid-ON (counter=20) → all outputs 0 immediately; re-start 9/3 → {0, 3} after 33 edges.
- DIV_EARLY_OUT_EN defined: op1=3, op2=10 unsigned → ready after 2 edges, result={3, 0}. Undefined: same stimulus → ready after 33 edges, same result.

Source files
------------

// File: rtl/mul_div_unit_div.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit_div
// Brief    : Multi-cycle radix-2 restoring divider (DIV/DIVU) producing
//            {remainder, quotient} and the busy/ready handshake for stalls.
//            Optional macro DIV_EARLY_OUT_EN skips iteration when |op1|<|op2|.
// Revision : 1.0
// ============================================================================
module mul_div_unit_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    input  logic                  annul,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready,
    output logic                  stall_div
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_DIVBYZERO = 2'd1;
    localparam logic [1:0] c_ON        = 2'd2;
    localparam logic [1:0] c_END       = 2'd3;

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(DATA_W - 1);

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_counter;
    logic [2*DATA_W:0]   r_shift;
    logic [DATA_W-1:0]   r_divisor;
    logic                r_quoNeg;
    logic                r_remNeg;
    logic [2*DATA_W-1:0] r_result;

    logic                w_op1Neg;
    logic                w_op2Neg;
    logic [DATA_W-1:0]   w_op1Mag;
    logic [DATA_W-1:0]   w_op2Mag;
    logic [DATA_W+1:0]   w_trial;
    logic [2*DATA_W:0]   w_nextShift;
    logic [DATA_W-1:0]   w_quotient;
    logic [DATA_W-1:0]   w_remainder;

    assign w_op1Neg = signed_div & opdata1[DATA_W-1];
    assign w_op2Neg = signed_div & opdata2[DATA_W-1];
    assign w_op1Mag = w_op1Neg ? -opdata1 : opdata1;
    assign w_op2Mag = w_op2Neg ? -opdata2 : opdata2;

    // Trial subtract on the left-shifted partial remainder; the extra top bit
    // of w_trial is the borrow that decides the quotient bit.
    assign w_trial     = r_shift[2*DATA_W:DATA_W-1] - {2'b00, r_divisor};
    assign w_nextShift = w_trial[DATA_W+1]
                       ? {r_shift[2*DATA_W-1:0], 1'b0}
                       : {w_trial[DATA_W:0], r_shift[DATA_W-2:0], 1'b1};
    assign w_quotient  = w_nextShift[DATA_W-1:0];
    assign w_remainder = w_nextShift[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= c_IDLE;
            r_counter <= '0;
            r_shift   <= '0;
            r_divisor <= '0;
            r_quoNeg  <= 1'b0;
            r_remNeg  <= 1'b0;
            r_result  <= '0;
        end else if (annul) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (opdata2 == '0) begin
                            r_state <= c_DIVBYZERO;
                            r_shift <= {{(DATA_W+1){1'b0}}, opdata1};
                        end
`ifdef DIV_EARLY_OUT_EN
                        else if (w_op1Mag < w_op2Mag) begin
                            r_state  <= c_END;
                            r_result <= {opdata1, {DATA_W{1'b0}}};
                        end
`endif
                        else begin
                            r_state   <= c_ON;
                            r_counter <= '0;
                            r_shift   <= {{(DATA_W+1){1'b0}}, w_op1Mag};
                            r_divisor <= w_op2Mag;
                            r_quoNeg  <= w_op1Neg ^ w_op2Neg;
                            r_remNeg  <= w_op1Neg;
                        end
                    end
                end
                c_DIVBYZERO: begin
                    r_state  <= c_END;
                    r_result <= {r_shift[DATA_W-1:0], {DATA_W{1'b1}}};
                end
                c_ON: begin
                    r_shift   <= w_nextShift;
                    r_counter <= r_counter + CNT_W'(1);
                    if (r_counter == c_LAST_CNT) begin
                        r_state  <= c_END;
                        r_result <= {r_remNeg ? -w_remainder : w_remainder,
                                     r_quoNeg ? -w_quotient  : w_quotient};
                    end
                end
                c_END: begin
                    if (!start) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign result    = r_result;
    assign ready     = (r_state == c_END);
    assign stall_div = start & ~ready;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit_div.sv
`default_nettype none
// Randomized self-checking bench for mul_div_unit_div against an arithmetic
// reference model (64-bit signed division) plus a latency model.
module tb_mul_div_unit_div;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_div;

    int          nChecks   = 0;
    int          nFailures = 0;
    logic [63:0] lastExp   = '0;

    mul_div_unit_div #(.DATA_W(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_div  (stall_div)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFailures++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Truncating division as the ISA defines it; -2^31/-1 wraps via 64-bit math.
    function automatic logic [63:0] modelDiv(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        logic signed [63:0] sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        sa = s ? {{32{a[31]}}, a} : {32'd0, a};
        sb = s ? {{32{b[31]}}, b} : {32'd0, b};
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int modelLatency(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
        logic [31:0] ma, mb;
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 2;
`else
        if (ma == mb + 32'd1) return 33;  // keeps ma/mb referenced in both builds
`endif
        return 33;
    endfunction

    // Issues one request, counts edges (accepting edge = 1) until ready,
    // scrambles operands after acceptance, then releases start.
    task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] exp;
        int          expLat;
        int          lat;
        exp    = modelDiv(a, b, s);
        expLat = modelLatency(a, b, s);
        @(negedge clk);
        opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1;
        #1 checkValue("stall_on_start", {63'd0, stall_div}, 64'd1);
        lat = 0;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                opdata1 = $urandom; opdata2 = $urandom; signed_div = ~s;
            end
        end
        checkValue("latency", 64'(lat), 64'(expLat));
        checkValue("result", result, exp);
        checkValue("stall_at_ready", {63'd0, stall_div}, 64'd0);
        lastExp = exp;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        checkValue("ready_drop", {63'd0, ready}, 64'd0);
    endtask

    initial begin
        logic        sawReady;
        logic [31:0] a, b;
        logic        s;
        int          kind;

        resetn = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset_result", result, 64'd0);
        checkValue("reset_ready", {63'd0, ready}, 64'd0);
        checkValue("reset_stall", {63'd0, stall_div}, 64'd0);
        @(negedge clk); resetn = 1'b1;

        runDiv(32'd100, 32'd7, 1'b0);
        runDiv(32'hFFFFFFF9, 32'd2, 1'b1);
        runDiv(32'h80000000, 32'hFFFFFFFF, 1'b1);
        runDiv(32'h12345678, 32'd0, 1'b0);
        runDiv(32'd3, 32'd10, 1'b0);
        runDiv(32'hFFFFFFFD, 32'd10, 1'b1);

        // Annul at counter=10: request dropped, result retained.
        @(negedge clk);
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk); annul = 1'b1;
        @(negedge clk); annul = 1'b0; start = 1'b0;
        sawReady = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) sawReady = 1'b1;
        end
        checkValue("annul_no_ready", {63'd0, sawReady}, 64'd0);
        checkValue("annul_result_kept", result, lastExp);
        runDiv(32'd5, 32'd2, 1'b0);

        // Annul together with start in IDLE: request ignored.
        @(negedge clk);
        opdata1 = 32'd50; opdata2 = 32'd0; start = 1'b1; annul = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0; annul = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkValue("annul_with_start", {63'd0, ready}, 64'd0);

        // Asynchronous reset mid-division at counter=20.
        @(negedge clk);
        opdata1 = 32'd12345; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2 resetn = 1'b0; start = 1'b0;
        #1;
        checkValue("midreset_result", result, 64'd0);
        checkValue("midreset_ready", {63'd0, ready}, 64'd0);
        checkValue("midreset_stall", {63'd0, stall_div}, 64'd0);
        @(negedge clk); resetn = 1'b1;
        runDiv(32'd9, 32'd3, 1'b0);

        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 3);
            s    = 1'($urandom_range(0, 1));
            a    = $urandom;
            case (kind)
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 300));
                2:       b = 32'd0;
                default: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(51, 100000)); end
            endcase
            runDiv(a, b, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFailures);
        $finish;
    end

endmodule
`default_nettype wire
